// File: rtl/seg_carry_adder.sv
// rtl/seg_carry_adder.sv - pipelined add/subtract with registered carries between SEG-bit segments
// An input register stage is followed by NSEG segment stages, so results appear NSEG edges after accept.
module seg_carry_adder #(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NSEG = (SEG > 0) ? WIDTH / SEG : 1;
  localparam int MSB  = WIDTH - 1;

  if (SEG < 1 || (WIDTH % SEG) != 0) begin : g_bad_params
    $error("seg_carry_adder: WIDTH must be a positive multiple of SEG");
  end

  // Index 0 is the captured operation; index k holds the result after segment k-1 is added.
  logic             v_r  [NSEG+1];
  logic             c_r  [NSEG+1];
  logic [WIDTH-1:0] s_r  [NSEG+1];
  logic [WIDTH-1:0] a_r  [NSEG];
  logic [WIDTH-1:0] bb_r [NSEG];
  logic             ovf_r;

  logic             n_v  [NSEG+1];
  logic             n_c  [NSEG+1];
  logic [WIDTH-1:0] n_s  [NSEG+1];
  logic [WIDTH-1:0] n_a  [NSEG];
  logic [WIDTH-1:0] n_bb [NSEG];
  logic             n_ovf;
  logic [SEG:0]     seg_sum [NSEG];
  logic             stall;

  always_comb begin
    // Bubbles carry zeros so idle operands never reach the output registers.
    n_v[0]  = in_valid;
    n_c[0]  = in_valid & (cin ^ sub);
    n_a[0]  = in_valid ? a : '0;
    n_bb[0] = in_valid ? (sub ? ~b : b) : '0;
    n_s[0]  = '0;
    for (int k = 1; k < NSEG; k++) begin
      n_a[k]  = a_r[k-1];
      n_bb[k] = bb_r[k-1];
    end
    for (int k = 1; k <= NSEG; k++) begin
      seg_sum[k-1] = {1'b0, a_r[k-1][(k-1)*SEG +: SEG]}
                   + {1'b0, bb_r[k-1][(k-1)*SEG +: SEG]}
                   + {{SEG{1'b0}}, c_r[k-1]};
      n_v[k] = v_r[k-1];
      n_c[k] = seg_sum[k-1][SEG];
      n_s[k] = s_r[k-1];
      n_s[k][(k-1)*SEG +: SEG] = seg_sum[k-1][SEG-1:0];
    end
    n_ovf = (a_r[NSEG-1][MSB] == bb_r[NSEG-1][MSB]) && (n_s[NSEG][MSB] != a_r[NSEG-1][MSB]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k <= NSEG; k++) begin
        v_r[k] <= 1'b0;
        c_r[k] <= 1'b0;
        s_r[k] <= '0;
      end
      for (int k = 0; k < NSEG; k++) begin
        a_r[k]  <= '0;
        bb_r[k] <= '0;
      end
      ovf_r <= 1'b0;
    end else if (!stall) begin
      for (int k = 0; k <= NSEG; k++) begin
        v_r[k] <= n_v[k];
        c_r[k] <= n_c[k];
        s_r[k] <= n_s[k];
      end
      for (int k = 0; k < NSEG; k++) begin
        a_r[k]  <= n_a[k];
        bb_r[k] <= n_bb[k];
      end
      ovf_r <= n_ovf;
    end
  end

  assign stall     = v_r[NSEG] && !out_ready;
  assign in_ready  = !stall;
  assign out_valid = v_r[NSEG];
  assign sum       = s_r[NSEG];
  assign cout      = c_r[NSEG];
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_seg_carry_adder.sv
// tb/tb_seg_carry_adder.sv - bench for seg_carry_adder at 32/8, 10/10 and 10/5
module tb_seg_carry_adder;

  typedef struct {
    logic [33:0] res;
    logic [33:0] lit;
    bit          hl;
    int          age;
  } ent_t;

  localparam int W  [3] = '{32, 10, 10};
  localparam int NS [3] = '{4, 1, 2};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  in_valid = '0, in_ready, out_valid, out_ready = 3'b111;
  logic [2:0]  cin = '0, sub = '0, cout, ovf;
  logic [31:0] a [3], b [3];
  logic [31:0] sum0;
  logic [9:0]  sum1, sum2;
  logic [33:0] lit_in [3];
  bit   [2:0]  has_lit = '0;
  bit          done = 1'b0;

  ent_t fifo [3][16];
  int   head [3], cnt [3];
  int   n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  seg_carry_adder #(.WIDTH(32), .SEG(8)) u_w32 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a[0]), .b(b[0]), .cin(cin[0]), .sub(sub[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .sum(sum0), .cout(cout[0]), .ovf(ovf[0]));

  seg_carry_adder #(.WIDTH(10), .SEG(10)) u_w10s1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a[1][9:0]), .b(b[1][9:0]), .cin(cin[1]), .sub(sub[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .sum(sum1), .cout(cout[1]), .ovf(ovf[1]));

  seg_carry_adder #(.WIDTH(10), .SEG(5)) u_w10s2 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .a(a[2][9:0]), .b(b[2][9:0]), .cin(cin[2]), .sub(sub[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .sum(sum2), .cout(cout[2]), .ovf(ovf[2]));

  // Reference result {ovf, cout, sum} from plain wide arithmetic.
  function automatic logic [33:0] model(int w, logic [31:0] av, logic [31:0] bv, logic ci, logic sb);
    longint unsigned m, x, y, t;
    logic co, am, bm, sm;
    m  = (64'd1 << w) - 64'd1;
    x  = {32'd0, av} & m;
    y  = (sb ? ~{32'd0, bv} : {32'd0, bv}) & m;
    t  = x + y + 64'(ci ^ sb);
    co = t[w];
    am = x[w-1];
    bm = y[w-1];
    sm = t[w-1];
    return {(am == bm) && (sm != am), co, 32'(t & m)};
  endfunction

  task automatic chk(string nm, int i, logic [33:0] got, logic [33:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s[%0d] got=%h want=%h at %0t", nm, i, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [33:0] got;
    logic        ev, st;
    ent_t        e;
    if (done) begin
      for (int i = 0; i < 3; i++) chk("drained", i, 34'(cnt[i]), 34'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
    end
    for (int i = 0; i < 3; i++) begin
      got = {ovf[i], cout[i], (i == 0) ? sum0 : (i == 1) ? {22'd0, sum1} : {22'd0, sum2}};
      if (rst) begin
        cnt[i] = 0;
        chk("rst_valid", i, 34'(out_valid[i]), 34'd0);
        chk("rst_data", i, got, 34'd0);
        chk("rst_ready", i, 34'(in_ready[i]), 34'd1);
      end else begin
        ev = cnt[i] > 0 && fifo[i][head[i]].age > NS[i];
        st = ev && !out_ready[i];
        chk("out_valid", i, 34'(out_valid[i]), 34'(ev));
        chk("in_ready", i, 34'(in_ready[i]), 34'(!st));
        if (ev) begin
          chk("result", i, got, fifo[i][head[i]].res);
          if (fifo[i][head[i]].hl) chk("literal", i, got, fifo[i][head[i]].lit);
        end
        if (!st) begin
          if (ev) begin
            head[i] = (head[i] + 1) % 16;
            cnt[i]--;
          end
          for (int j = 0; j < cnt[i]; j++) fifo[i][(head[i] + j) % 16].age++;
          if (in_valid[i]) begin
            e.res = model(W[i], a[i], b[i], cin[i], sub[i]);
            e.lit = lit_in[i];
            e.hl  = has_lit[i];
            e.age = 1;
            fifo[i][(head[i] + cnt[i]) % 16] = e;
            cnt[i]++;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic op(int i, logic [31:0] av, logic [31:0] bv, logic ci, logic sb, logic [33:0] lv, bit hl);
    a[i] = av; b[i] = bv; cin[i] = ci; sub[i] = sb;
    lit_in[i] = lv; has_lit[i] = hl; in_valid[i] = 1'b1;
    step();
    in_valid[i] = 1'b0; has_lit[i] = 1'b0;
  endtask

  initial begin
    int issued;
    for (int i = 0; i < 3; i++) begin
      a[i] = '0; b[i] = '0; lit_in[i] = '0; head[i] = 0; cnt[i] = 0;
    end
    repeat (3) step();
    rst = 1'b0;

    op(0, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, {1'b0, 1'b1, 32'h0000_0000}, 1'b1);
    op(0, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, {1'b1, 1'b0, 32'h8000_0000}, 1'b1);
    op(0, 32'h5,         32'h7, 1'b0, 1'b1, {1'b0, 1'b0, 32'hFFFF_FFFE}, 1'b1);
    op(0, 32'h7,         32'h5, 1'b1, 1'b1, {1'b0, 1'b1, 32'h0000_0001}, 1'b1);
    op(0, 32'h00FF_FFFF, 32'h1, 1'b0, 1'b0, {1'b0, 1'b0, 32'h0100_0000}, 1'b1);
    op(0, 32'h8000_0000, 32'h1, 1'b0, 1'b1, {1'b1, 1'b1, 32'h7FFF_FFFF}, 1'b1);
    for (int c = 0; c < 8; c++) begin
      a[0] = $urandom; b[0] = $urandom; cin[0] = 1'($urandom); sub[0] = 1'($urandom);
      step();
    end

    issued = 0;
    cin[0] = 1'b0; sub[0] = 1'b0;
    for (int c = 0; c < 24; c++) begin
      out_ready[0] = !(c >= 5 && c <= 7);
      in_valid[0]  = issued < 8;
      a[0] = 32'(issued);
      b[0] = 32'(issued) << 24;
      @(negedge clk);
      if (in_valid[0] && in_ready[0]) issued++;
      step();
    end
    in_valid[0] = 1'b0; out_ready[0] = 1'b1;

    op(0, 32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0, 34'd0, 1'b0);
    op(0, 32'h3333_3333, 32'h4444_4444, 1'b1, 1'b0, 34'd0, 1'b0);
    op(0, 32'h5555_5555, 32'h6666_6666, 1'b0, 1'b1, 34'd0, 1'b0);
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    op(0, 32'd2, 32'd3, 1'b0, 1'b0, {2'b00, 32'd5}, 1'b1);
    repeat (6) step();

    op(1, 32'h3FF, 32'h001, 1'b0, 1'b0, {1'b0, 1'b1, 32'h000}, 1'b1);
    op(1, 32'h1FF, 32'h001, 1'b0, 1'b0, {1'b1, 1'b0, 32'h200}, 1'b1);
    op(1, 32'h000, 32'h001, 1'b0, 1'b1, {1'b0, 1'b0, 32'h3FF}, 1'b1);
    op(2, 32'h3FF, 32'h001, 1'b0, 1'b0, {1'b0, 1'b1, 32'h000}, 1'b1);
    op(2, 32'h01F, 32'h001, 1'b0, 1'b0, {1'b0, 1'b0, 32'h020}, 1'b1);
    op(2, 32'h000, 32'h001, 1'b0, 1'b1, {1'b0, 1'b0, 32'h3FF}, 1'b1);
    repeat (10) step();
    done = 1'b1;
    repeat (5) step();
    $display("FAIL watchdog[0] got=done want=finished");
    $fatal(1);
  end

endmodule
